// File: rtl/connect_four_pkg.sv
// Shared types and constants for the Connect Four game controller.
// Optional turn timer is enabled with `TURN_TIMEOUT_EN in connect_four_controller.
package connect_four_pkg;

  localparam int unsigned ROWS      = 6;
  localparam int unsigned COLS      = 8;
  localparam int unsigned MAX_MOVES = 48;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned COL_W     = 3;
  localparam int unsigned MOVE_W    = 6;
  localparam int unsigned PIECE_W   = 2;

  typedef enum logic [PIECE_W-1:0] {
    PIECE_NONE = 2'b00,
    PIECE_P1   = 2'b01,
    PIECE_P2   = 2'b10
  } piece_t;

  typedef enum logic [2:0] {
    CLEAR,
    WAIT,
    SCAN,
    WRITE,
    CHECK,
    SWITCH,
    WIN,
    DRAW
  } state_t;

  // Board write request presented to the datapath
  typedef struct packed {
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [PIECE_W-1:0] val;
  } wr_req_t;

  // Cursor step with wrap; simultaneous left+right cancels out
  function automatic logic [COL_W-1:0] cursor_step(input logic [COL_W-1:0] col,
                                                   input logic left,
                                                   input logic right);
    logic [COL_W-1:0] res;
    res = col;
    if (left && !right) begin
      res = col - COL_W'(1);
    end else if (right && !left) begin
      res = col + COL_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/connect_four_blink_gen.sv
// Free-running blink square wave: toggles every BLINK_DIV clock cycles.
module connect_four_blink_gen #(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic blink
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else if (r_cnt == CNT_W'(BLINK_DIV - 1)) begin
      r_cnt   <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign blink = r_blink;

endmodule

// File: rtl/connect_four_controller.sv
// Connect Four game-sequencing FSM: cursor, player, move count, board writes and win/draw flags.
// Define TURN_TIMEOUT_EN to forfeit a turn after TURN_CYCLES idle cycles in WAIT.
module connect_four_controller
  import connect_four_pkg::*;
#(
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned TURN_CYCLES = 500_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_drop,
  input  logic               btn_new_game,
  input  logic [PIECE_W-1:0] board [ROWS][COLS],
  input  logic               win_done,
  input  logic               win_found,
  output logic               wr_en,
  output logic [ROW_W-1:0]   wr_row,
  output logic [COL_W-1:0]   wr_col,
  output logic [PIECE_W-1:0] wr_val,
  output logic               clear_board,
  output logic               win_start,
  output logic [COL_W-1:0]   cursor_col,
  output logic [PIECE_W-1:0] current_player,
  output logic               blink,
  output logic               update_display,
  output logic               winner_enable,
  output logic               game_over_enable
);

  state_t              r_state,     w_state;
  logic [COL_W-1:0]    r_cursor,    w_cursor;
  piece_t              r_player,    w_player;
  logic [MOVE_W-1:0]   r_move_cnt,  w_move_cnt;
  logic [ROW_W-1:0]    r_scan_row,  w_scan_row;
  wr_req_t             r_wr,        w_wr;
  logic                r_wr_en,     w_wr_en;
  logic                r_clear,     w_clear;
  logic                r_win_start, w_win_start;
  logic                r_update,    w_update;
  logic                r_winner,    w_winner;
  logic                r_game_over, w_game_over;

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  logic [TURN_W-1:0] r_turn_cnt, w_turn_cnt;
`else
  logic w_unused_turn_cfg;
  assign w_unused_turn_cfg = ^TURN_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_cursor    <= '0;
      r_player    <= PIECE_P1;
      r_move_cnt  <= '0;
      r_scan_row  <= '0;
      r_wr        <= '0;
      r_wr_en     <= 1'b0;
      r_clear     <= 1'b0;
      r_win_start <= 1'b0;
      r_update    <= 1'b0;
      r_winner    <= 1'b0;
      r_game_over <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      r_turn_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_cursor    <= w_cursor;
      r_player    <= w_player;
      r_move_cnt  <= w_move_cnt;
      r_scan_row  <= w_scan_row;
      r_wr        <= w_wr;
      r_wr_en     <= w_wr_en;
      r_clear     <= w_clear;
      r_win_start <= w_win_start;
      r_update    <= w_update;
      r_winner    <= w_winner;
      r_game_over <= w_game_over;
`ifdef TURN_TIMEOUT_EN
      r_turn_cnt  <= w_turn_cnt;
`endif
    end
  end

  // Next-state and next-output logic; strobes default low, flags are held only by WIN/DRAW
  always_comb begin
    w_state     = r_state;
    w_cursor    = r_cursor;
    w_player    = r_player;
    w_move_cnt  = r_move_cnt;
    w_scan_row  = r_scan_row;
    w_wr        = r_wr;
    w_wr_en     = 1'b0;
    w_clear     = 1'b0;
    w_win_start = 1'b0;
    w_update    = 1'b0;
    w_winner    = 1'b0;
    w_game_over = 1'b0;
`ifdef TURN_TIMEOUT_EN
    w_turn_cnt  = r_turn_cnt;
`endif

    if (btn_new_game) begin
      w_state = CLEAR;
    end else begin
      unique case (r_state)
        CLEAR: begin
          w_clear    = 1'b1;
          w_cursor   = '0;
          w_player   = PIECE_P1;
          w_move_cnt = '0;
          w_update   = 1'b1;
          w_state    = WAIT;
`ifdef TURN_TIMEOUT_EN
          w_turn_cnt = '0;
`endif
        end
        WAIT: begin
          if (btn_drop) begin
            w_scan_row = ROW_W'(ROWS - 1);
            w_state    = SCAN;
          end else begin
            w_cursor = cursor_step(r_cursor, btn_left, btn_right);
            w_update = (w_cursor != r_cursor);
`ifdef TURN_TIMEOUT_EN
            if (r_turn_cnt == TURN_W'(TURN_CYCLES - 1)) begin
              w_state = SWITCH;
            end else begin
              w_turn_cnt = r_turn_cnt + TURN_W'(1);
            end
`endif
          end
        end
        SCAN: begin
          if (board[r_scan_row][r_cursor] == PIECE_NONE) begin
            w_wr_en    = 1'b1;
            w_wr       = '{row: r_scan_row, col: r_cursor, val: r_player};
            w_move_cnt = r_move_cnt + MOVE_W'(1);
            w_update   = 1'b1;
            w_state    = WRITE;
          end else if (r_scan_row == '0) begin
            w_state = WAIT;
          end else begin
            w_scan_row = r_scan_row - ROW_W'(1);
          end
        end
        WRITE: begin
          // Checker samples one cycle after the write strobe so the board is committed
          w_win_start = 1'b1;
          w_state     = CHECK;
        end
        CHECK: begin
          if (win_done) begin
            if (win_found) begin
              w_winner = 1'b1;
              w_update = 1'b1;
              w_state  = WIN;
            end else if (r_move_cnt == MOVE_W'(MAX_MOVES)) begin
              w_game_over = 1'b1;
              w_update    = 1'b1;
              w_state     = DRAW;
            end else begin
              w_state = SWITCH;
            end
          end
        end
        SWITCH: begin
          w_player = (r_player == PIECE_P1) ? PIECE_P2 : PIECE_P1;
          w_update = 1'b1;
          w_state  = WAIT;
`ifdef TURN_TIMEOUT_EN
          w_turn_cnt = '0;
`endif
        end
        WIN: begin
          w_winner = 1'b1;
        end
        DRAW: begin
          w_game_over = 1'b1;
        end
        default: begin
          w_state = CLEAR;
        end
      endcase
    end
  end

  connect_four_blink_gen #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .blink(blink)
  );

  assign wr_en            = r_wr_en;
  assign wr_row           = r_wr.row;
  assign wr_col           = r_wr.col;
  assign wr_val           = r_wr.val;
  assign clear_board      = r_clear;
  assign win_start        = r_win_start;
  assign cursor_col       = r_cursor;
  assign current_player   = r_player;
  assign update_display   = r_update;
  assign winner_enable    = r_winner;
  assign game_over_enable = r_game_over;

endmodule

// File: tb/tb_connect_four_controller.sv
// Directed self-checking bench for connect_four_controller (BLINK_DIV=4, TURN_CYCLES=10).
`timescale 1ns/1ps
module tb_connect_four_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_drop = 1'b0, btn_new_game = 1'b0;
  logic [1:0] board [6][8];
  logic       win_done = 1'b0, win_found = 1'b0;
  logic       wr_en, clear_board, win_start, blink, update_display;
  logic       winner_enable, game_over_enable;
  logic [2:0] wr_row, wr_col, cursor_col;
  logic [1:0] wr_val, current_player;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  connect_four_controller #(
    .BLINK_DIV  (4),
    .TURN_CYCLES(10)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_left        (btn_left),
    .btn_right       (btn_right),
    .btn_drop        (btn_drop),
    .btn_new_game    (btn_new_game),
    .board           (board),
    .win_done        (win_done),
    .win_found       (win_found),
    .wr_en           (wr_en),
    .wr_row          (wr_row),
    .wr_col          (wr_col),
    .wr_val          (wr_val),
    .clear_board     (clear_board),
    .win_start       (win_start),
    .cursor_col      (cursor_col),
    .current_player  (current_player),
    .blink           (blink),
    .update_display  (update_display),
    .winner_enable   (winner_enable),
    .game_over_enable(game_over_enable)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_model();
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) begin
        board[r][c] = 2'b00;
      end
    end
  endtask

  // One-cycle button pulse issued at a falling edge; returns at the next falling edge
  task automatic press(input logic l, input logic r, input logic d, input logic n);
    btn_left = l; btn_right = r; btn_drop = d; btn_new_game = n;
    tick();
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0; btn_new_game = 1'b0;
  endtask

  task automatic new_game();
    press(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_model();
  endtask

  // Drop and observe the write (bounded); the board model commits what was written
  task automatic drop_piece(output logic got_wr, output logic [2:0] got_row,
                            output logic [2:0] got_col, output logic [1:0] got_val);
    got_wr = 1'b0; got_row = '0; got_col = '0; got_val = '0;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (wr_en) begin
        got_wr = 1'b1; got_row = wr_row; got_col = wr_col; got_val = wr_val;
        board[wr_row][wr_col] = wr_val;
        break;
      end
      tick();
    end
  endtask

  task automatic respond(input logic found);
    win_done = 1'b1; win_found = found;
    tick();
    win_done = 1'b0; win_found = 1'b0;
  endtask

  task automatic play_quiet(input int n);
    logic w; logic [2:0] r, c; logic [1:0] v;
    for (int i = 0; i < n; i++) begin
      drop_piece(w, r, c, v);
      tick();
      respond(1'b0);
      tick();
      clear_model();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if ({cursor_col, current_player} !== {3'd0, 2'b01}) begin errors++;
      $display("FAIL reset_cursor_player: got col=%0d player=%b expected col=0 player=01", cursor_col, current_player); end
    checks++; if ({wr_en, clear_board, win_start, update_display, winner_enable, game_over_enable, blink} !== 7'b0) begin errors++;
      $display("FAIL reset_strobes: got %b expected 0000000", {wr_en, clear_board, win_start, update_display, winner_enable, game_over_enable, blink}); end
    rst_n = 1'b1;
    tick();
    checks++; if ({clear_board, update_display} !== 2'b11) begin errors++;
      $display("FAIL clear_pulse: got clear=%b update=%b expected 1 1", clear_board, update_display); end
    tick();
    checks++; if ({clear_board, update_display} !== 2'b00) begin errors++;
      $display("FAIL clear_one_cycle: got clear=%b update=%b expected 0 0", clear_board, update_display); end
  endtask

  task automatic test_cursor();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if ({cursor_col, update_display} !== {3'd7, 1'b1}) begin errors++;
      $display("FAIL cursor_wrap_left: got col=%0d upd=%b expected col=7 upd=1", cursor_col, update_display); end
    tick();
    checks++; if (update_display !== 1'b0) begin errors++;
      $display("FAIL cursor_update_pulse: got %b expected 0", update_display); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (cursor_col !== 3'd0) begin errors++;
      $display("FAIL cursor_wrap_right: got %0d expected 0", cursor_col); end
    press(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if ({cursor_col, update_display} !== {3'd0, 1'b0}) begin errors++;
      $display("FAIL cursor_both: got col=%0d upd=%b expected col=0 upd=0", cursor_col, update_display); end
  endtask

  task automatic test_drop();
    logic w; logic [2:0] r, c; logic [1:0] v;
    new_game();
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (cursor_col !== 3'd3) begin errors++;
      $display("FAIL drop_cursor: got %0d expected 3", cursor_col); end
    drop_piece(w, r, c, v);
    checks++; if ({w, r, c, v} !== {1'b1, 3'd5, 3'd3, 2'b01}) begin errors++;
      $display("FAIL drop_first_write: got wr=%b row=%0d col=%0d val=%b expected 1 5 3 01", w, r, c, v); end
    tick();
    checks++; if ({win_start, wr_en} !== 2'b10) begin errors++;
      $display("FAIL win_start_after_write: got start=%b wr=%b expected 1 0", win_start, wr_en); end
    tick();
    checks++; if (win_start !== 1'b0) begin errors++;
      $display("FAIL win_start_once: got %b expected 0", win_start); end
    respond(1'b0);
    tick();
    checks++; if ({current_player, update_display} !== {2'b10, 1'b1}) begin errors++;
      $display("FAIL switch_to_p2: got player=%b upd=%b expected 10 1", current_player, update_display); end
    drop_piece(w, r, c, v);
    checks++; if ({w, r, c, v} !== {1'b1, 3'd4, 3'd3, 2'b10}) begin errors++;
      $display("FAIL drop_second_write: got wr=%b row=%0d col=%0d val=%b expected 1 4 3 10", w, r, c, v); end
    tick();
    respond(1'b0);
    tick();
    checks++; if (current_player !== 2'b01) begin errors++;
      $display("FAIL switch_back_p1: got %b expected 01", current_player); end
  endtask

  task automatic test_full_column();
    logic w; logic [2:0] r, c; logic [1:0] v;
    new_game();
    for (int i = 0; i < 6; i++) board[i][2] = 2'b01;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    drop_piece(w, r, c, v);
    checks++; if ({w, current_player} !== {1'b0, 2'b01}) begin errors++;
      $display("FAIL full_column_no_write: got wr=%b player=%b expected 0 01", w, current_player); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (cursor_col !== 3'd3) begin errors++;
      $display("FAIL full_column_back_to_wait: got col=%0d expected 3", cursor_col); end
    clear_model();
  endtask

  task automatic test_win();
    logic w; logic [2:0] r, c; logic [1:0] v;
    new_game();
    drop_piece(w, r, c, v);
    tick();
    respond(1'b1);
    checks++; if ({winner_enable, update_display, game_over_enable} !== 3'b110) begin errors++;
      $display("FAIL win_entry: got win=%b upd=%b over=%b expected 1 1 0", winner_enable, update_display, game_over_enable); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    drop_piece(w, r, c, v);
    checks++; if ({w, cursor_col, winner_enable, update_display} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin errors++;
      $display("FAIL win_ignores_buttons: got wr=%b col=%0d win=%b upd=%b expected 0 0 1 0", w, cursor_col, winner_enable, update_display); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (winner_enable !== 1'b0) begin errors++;
      $display("FAIL win_new_game_exit: got %b expected 0", winner_enable); end
    tick();
    checks++; if (clear_board !== 1'b1) begin errors++;
      $display("FAIL win_new_game_clear: got %b expected 1", clear_board); end
    clear_model();
  endtask

  task automatic test_draw();
    logic w; logic [2:0] r, c; logic [1:0] v;
    new_game();
    play_quiet(47);
    checks++; if ({game_over_enable, winner_enable, current_player} !== {1'b0, 1'b0, 2'b10}) begin errors++;
      $display("FAIL draw_after_47: got over=%b win=%b player=%b expected 0 0 10", game_over_enable, winner_enable, current_player); end
    drop_piece(w, r, c, v);
    checks++; if ({w, r, v} !== {1'b1, 3'd5, 2'b10}) begin errors++;
      $display("FAIL draw_move48_write: got wr=%b row=%0d val=%b expected 1 5 10", w, r, v); end
    tick();
    respond(1'b0);
    checks++; if ({game_over_enable, winner_enable, update_display} !== 3'b101) begin errors++;
      $display("FAIL draw_entry: got over=%b win=%b upd=%b expected 1 0 1", game_over_enable, winner_enable, update_display); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if ({game_over_enable, cursor_col} !== {1'b1, 3'd0}) begin errors++;
      $display("FAIL draw_held: got over=%b col=%0d expected 1 0", game_over_enable, cursor_col); end
    new_game();
    checks++; if (game_over_enable !== 1'b0) begin errors++;
      $display("FAIL draw_exit: got %b expected 0", game_over_enable); end
  endtask

  task automatic test_win_on_last();
    logic w; logic [2:0] r, c; logic [1:0] v;
    new_game();
    play_quiet(47);
    drop_piece(w, r, c, v);
    tick();
    respond(1'b1);
    checks++; if ({winner_enable, game_over_enable} !== 2'b10) begin errors++;
      $display("FAIL win_on_move48: got win=%b over=%b expected 1 0", winner_enable, game_over_enable); end
    new_game();
  endtask

  task automatic test_new_game_in_check();
    logic w; logic [2:0] r, c; logic [1:0] v;
    new_game();
    drop_piece(w, r, c, v);
    tick();
    press(1'b0, 1'b0, 1'b0, 1'b1);
    win_done = 1'b1; win_found = 1'b1;
    tick();
    checks++; if ({clear_board, winner_enable} !== 2'b10) begin errors++;
      $display("FAIL check_abort_clear: got clear=%b win=%b expected 1 0", clear_board, winner_enable); end
    win_done = 1'b0; win_found = 1'b0;
    tick();
    checks++; if ({winner_enable, game_over_enable, current_player, cursor_col} !== {1'b0, 1'b0, 2'b01, 3'd0}) begin errors++;
      $display("FAIL check_abort_late_done: got win=%b over=%b player=%b col=%0d expected 0 0 01 0",
               winner_enable, game_over_enable, current_player, cursor_col); end
    clear_model();
  endtask

  task automatic test_blink();
    logic prev;
    int last_edge, n_edges;
    last_edge = -1; n_edges = 0;
    prev = blink;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (blink !== prev) begin
        if (last_edge >= 0) begin
          checks++; if (i - last_edge != 4) begin errors++;
            $display("FAIL blink_period: got %0d cycles expected 4", i - last_edge); end
        end
        last_edge = i;
        n_edges++;
        prev = blink;
      end
    end
    checks++; if (n_edges < 4) begin errors++;
      $display("FAIL blink_toggles: got %0d toggles expected at least 4", n_edges); end
  endtask

`ifdef TURN_TIMEOUT_EN
  task automatic test_timeout();
    logic saw_wr;
    saw_wr = 1'b0;
    press(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    clear_model();
    for (int i = 0; i < 9; i++) begin
      tick();
      saw_wr = saw_wr | wr_en;
    end
    checks++; if (current_player !== 2'b01) begin errors++;
      $display("FAIL timeout_early: got %b expected 01", current_player); end
    tick(); saw_wr = saw_wr | wr_en;
    tick(); saw_wr = saw_wr | wr_en;
    checks++; if ({current_player, saw_wr} !== {2'b10, 1'b0}) begin errors++;
      $display("FAIL timeout_switch: got player=%b wr_seen=%b expected 10 0", current_player, saw_wr); end
  endtask
`endif

  initial begin
    clear_model();
    test_reset();
    test_cursor();
    test_drop();
    test_full_column();
    test_win();
    test_draw();
    test_win_on_last();
    test_new_game_in_check();
    test_blink();
`ifdef TURN_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
